// File: rtl/spc_timer_io_if.sv
// CPU/BRAM bus bundle for the SPC timer and I/O window block.
// The master drives address, write data, strobe and BRAM read data; the slave returns the rest.
interface spc_timer_io_if;
  logic [15:0] in_address;
  logic [7:0]  in_write;
  logic        in_write_enable;
  logic [7:0]  out_read;
  logic [7:0]  in_ram_read;
  logic        out_ram_write_enable;

  modport master (
    output in_address,
    output in_write,
    output in_write_enable,
    output in_ram_read,
    input  out_read,
    input  out_ram_write_enable
  );

  modport slave (
    input  in_address,
    input  in_write,
    input  in_write_enable,
    input  in_ram_read,
    output out_read,
    output out_ram_write_enable
  );
endinterface

// File: rtl/spc_timer_io.sv
// Memory-mapped I/O window at 0x00F0-0x00FF with three two-stage timers (8-bit divider,
// 4-bit read-to-clear output counter); all other addresses fall through to a 1-cycle BRAM.
module spc_timer_io #(
  parameter int unsigned T01_DIV = 128,
  parameter int unsigned T2_DIV  = 16
) (
  input logic           clock,
  input logic           reset,
  spc_timer_io_if.slave bus
);

  localparam int unsigned     PreW    = (T01_DIV > 1) ? $clog2(T01_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(T01_DIV - 1);
  localparam logic [PreW-1:0] T2Mask  = PreW'(T2_DIV - 1);

  logic            io_window;
  logic [3:0]      io_idx;
  logic            rd_cycle;
  logic            ctrl_wr;

  logic [PreW-1:0] pre_q, pre_d;
  logic            tick01, tick2;

  logic [2:0]      en_q, en_d;
  logic [2:0][7:0] div_q, div_d;
  logic [2:0][7:0] stage_q, stage_d;
  logic [2:0][3:0] tout_q, tout_d;

  logic [2:0]      tick, en_rise, adv, wrap, rd_clr, div_wr;
  logic [2:0][7:0] stage_inc;

  logic            io_sel_q;
  logic [7:0]      io_data_q, io_data_d;

  assign io_window = (bus.in_address[15:4] == 12'h00F);
  assign io_idx    = bus.in_address[3:0];
  assign rd_cycle  = ~bus.in_write_enable;
  assign ctrl_wr   = bus.in_write_enable & io_window & (io_idx == 4'h1);

  assign bus.out_ram_write_enable = bus.in_write_enable & ~io_window;
  assign bus.out_read             = io_sel_q ? io_data_q : bus.in_ram_read;

  assign tick01 = (pre_q == PreLast);
  assign tick2  = ((pre_q & T2Mask) == T2Mask);
  assign pre_d  = tick01 ? '0 : pre_q + 1'b1;

  always_comb begin
    tick      = '0;
    en_rise   = '0;
    div_wr    = '0;
    rd_clr    = '0;
    stage_inc = '0;
    adv       = '0;
    wrap      = '0;
    en_d      = en_q;
    div_d     = div_q;
    stage_d   = stage_q;
    tout_d    = tout_q;
    for (int i = 0; i < 3; i++) begin
      tick[i]      = (i == 2) ? tick2 : tick01;
      en_rise[i]   = ctrl_wr & bus.in_write[i] & ~en_q[i];
      div_wr[i]    = bus.in_write_enable & io_window & (io_idx == 4'(10 + i));
      rd_clr[i]    = rd_cycle & io_window & (io_idx == 4'(13 + i));
      stage_inc[i] = stage_q[i] + 8'd1;
      adv[i]       = en_q[i] & tick[i];
      // 8-bit wrap makes a divisor of 0 match after 256 ticks
      wrap[i]      = adv[i] & (stage_inc[i] == div_q[i]);
      if (ctrl_wr) en_d[i] = bus.in_write[i];
      if (div_wr[i]) div_d[i] = bus.in_write;
      if (en_rise[i]) begin
        stage_d[i] = '0;
        tout_d[i]  = '0;
      end else begin
        if (wrap[i]) begin
          stage_d[i] = '0;
        end else if (adv[i]) begin
          stage_d[i] = stage_inc[i];
        end
        // A read-clear racing an increment keeps the increment
        if (rd_clr[i]) begin
          tout_d[i] = {3'b000, wrap[i]};
        end else begin
          tout_d[i] = tout_q[i] + {3'b000, wrap[i]};
        end
      end
    end
  end

  always_comb begin
    io_data_d = io_data_q;
    if (rd_cycle) begin
      io_data_d = '0;
      if (io_window) begin
        case (io_idx)
          4'hD:    io_data_d = {4'b0000, tout_q[0]};
          4'hE:    io_data_d = {4'b0000, tout_q[1]};
          4'hF:    io_data_d = {4'b0000, tout_q[2]};
          default: io_data_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q     <= '0;
      en_q      <= '0;
      div_q     <= '0;
      stage_q   <= '0;
      tout_q    <= '0;
      io_sel_q  <= 1'b0;
      io_data_q <= '0;
    end else begin
      pre_q     <= pre_d;
      en_q      <= en_d;
      div_q     <= div_d;
      stage_q   <= stage_d;
      tout_q    <= tout_d;
      io_sel_q  <= io_window;
      io_data_q <= io_data_d;
    end
  end

endmodule

// File: tb/tb_spc_timer_io.sv
// Bench for spc_timer_io: constant vector table, directed timer sequences and a random run,
// all cross-checked every cycle against a cycle-count based reference model.
module tb_spc_timer_io;

  localparam int unsigned T01 = 128;
  localparam int unsigned T2  = 16;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  spc_timer_io_if bus ();

  spc_timer_io #(
    .T01_DIV(T01),
    .T2_DIV (T2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // BRAM stand-in: read-first, unwritten locations hold addr ^ 0xA5
  logic [7:0] mem     [4096];
  bit         written [4096];
  always @(posedge clock) begin
    if (bus.out_ram_write_enable) begin
      mem[bus.in_address[11:0]]     <= bus.in_write;
      written[bus.in_address[11:0]] <= 1'b1;
    end
    bus.in_ram_read <= written[bus.in_address[11:0]] ? mem[bus.in_address[11:0]]
                                                     : (bus.in_address[7:0] ^ 8'hA5);
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  int       m_cyc;
  int       m_en    [3];
  int       m_div   [3];
  int       m_stage [3];
  int       m_out   [3];
  int       m_ram   [int];
  int       exp_data;
  int       exp_ram_rd;
  bit       exp_sel;
  bit       ram_rd_valid = 1'b0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        exp_wen;
    logic        chk_rd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic int ram_val(input logic [11:0] a);
    if (m_ram.exists(int'(a))) return m_ram[int'(a)];
    return int'(a[7:0] ^ 8'hA5);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_en[i]    = 0;
      m_div[i]   = 0;
      m_stage[i] = 0;
      m_out[i]   = 0;
    end
    m_cyc    = 0;
    exp_sel  = 1'b0;
    exp_data = 0;
  endtask

  task automatic model_step(input logic [15:0] a, input logic [7:0] d, input logic w,
                            input bit win);
    bit t01, t2, tk, rise, inc;
    int lim;
    t01 = (m_cyc % T01) == T01 - 1;
    t2  = (m_cyc % T2) == T2 - 1;
    m_cyc++;
    exp_ram_rd   = ram_val(a[11:0]);
    ram_rd_valid = 1'b1;
    if (w && !win) m_ram[int'(a[11:0])] = int'(d);
    exp_sel = win;
    if (!w) exp_data = (win && int'(a) >= 'hFD) ? m_out[int'(a) - 'hFD] : 0;
    for (int i = 0; i < 3; i++) begin
      tk   = (i == 2) ? t2 : t01;
      rise = w && a == 16'h00F1 && d[i] && m_en[i] == 0;
      lim  = (m_div[i] == 0) ? 256 : m_div[i];
      inc  = 1'b0;
      if (rise) begin
        m_stage[i] = 0;
        m_out[i]   = 0;
      end else begin
        if (m_en[i] != 0 && tk) begin
          if (m_stage[i] + 1 == lim) begin
            m_stage[i] = 0;
            inc        = 1'b1;
          end else begin
            m_stage[i] = (m_stage[i] + 1) % 256;
          end
        end
        if (!w && int'(a) == 'hFD + i) m_out[i] = int'(inc);
        else m_out[i] = (m_out[i] + int'(inc)) % 16;
      end
    end
    if (w && a == 16'h00F1) for (int i = 0; i < 3; i++) m_en[i] = int'(d[i]);
    if (w && int'(a) >= 'hFA && int'(a) <= 'hFC) m_div[int'(a) - 'hFA] = int'(d);
  endtask

  task automatic cycle(input logic [15:0] a, input logic [7:0] d, input logic w);
    bit win;
    bus.in_address      = a;
    bus.in_write        = d;
    bus.in_write_enable = w;
    #1;
    win = (a >= 16'h00F0) && (a <= 16'h00FF);
    chk("ram_write_enable", {31'd0, bus.out_ram_write_enable}, {31'd0, w && !win});
    model_step(a, d, w, win);
    @(posedge clock);
    #1;
    chk("out_read", {24'd0, bus.out_read}, exp_sel ? exp_data : exp_ram_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(16'h0000, 8'h00, 1'b0);
  endtask

  task automatic rd_io(input logic [15:0] a, input logic [7:0] exp, input string nm);
    cycle(a, 8'h00, 1'b0);
    chk(nm, {24'd0, bus.out_read}, {24'd0, exp});
  endtask

  task automatic do_reset();
    bus.in_address      = 16'h0000;
    bus.in_write        = 8'h00;
    bus.in_write_enable = 1'b0;
    reset               = 1'b1;
    #1;
    if (ram_rd_valid) chk("reset_async_out_read", {24'd0, bus.out_read}, exp_ram_rd);
    bus.in_address      = 16'h0030;
    bus.in_write_enable = 1'b1;
    #1;
    chk("reset_ram_we_ram", {31'd0, bus.out_ram_write_enable}, 32'd1);
    bus.in_address = 16'h00F1;
    #1;
    chk("reset_ram_we_io", {31'd0, bus.out_ram_write_enable}, 32'd0);
    bus.in_address      = 16'h0000;
    bus.in_write_enable = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    exp_ram_rd   = ram_val(12'h000);
    ram_rd_valid = 1'b1;
    chk("reset_out_read", {24'd0, bus.out_read}, exp_ram_rd);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{16'h0012, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{16'h0012, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[2]  = '{16'h00FD, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{16'h00FD, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{16'h00EF, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{16'h0100, 8'h44, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{16'h00EF, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[7]  = '{16'h0100, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44};
    tbl[8]  = '{16'h00F0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{16'h00F0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[10] = '{16'h10F5, 8'h66, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{16'h10F5, 8'h00, 1'b0, 1'b0, 1'b1, 8'h66};
    tbl[12] = '{16'h00FF, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{16'h00FA, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};

    model_reset();
    do_reset();

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].addr, tbl[i].wdata, tbl[i].we);
      chk($sformatf("vec%0d_wen", i), {31'd0, bus.out_ram_write_enable}, {31'd0, tbl[i].exp_wen});
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), {24'd0, bus.out_read}, {24'd0, tbl[i].exp_rd});
    end

    // Timer 2 at 64 kHz with divisor 1: 10 counts after 160 cycles, then read-to-clear
    do_reset();
    cycle(16'h00FC, 8'h01, 1'b1);
    cycle(16'h00F1, 8'h04, 1'b1);
    idle(159);
    rd_io(16'h00FF, 8'h0A, "t2_after_160");
    rd_io(16'h00FF, 8'h00, "t2_reread_cleared");

    do_reset();
    cycle(16'h00FC, 8'h01, 1'b1);
    cycle(16'h00F1, 8'h04, 1'b1);
    idle(239);
    rd_io(16'h00FF, 8'h0F, "t2_after_240");

    do_reset();
    cycle(16'h00FC, 8'h01, 1'b1);
    cycle(16'h00F1, 8'h04, 1'b1);
    idle(255);
    rd_io(16'h00FF, 8'h00, "t2_wrap_256");

    // Timers 0/1 with divisor 0 (256): first count lands exactly on edge 256*128
    do_reset();
    cycle(16'h00FA, 8'h00, 1'b1);
    cycle(16'h00F1, 8'h03, 1'b1);
    idle(32765);
    rd_io(16'h00FD, 8'h00, "t0_clear_races_inc");
    rd_io(16'h00FE, 8'h01, "t1_after_256_ticks");
    cycle(16'h00F1, 8'h02, 1'b1);
    cycle(16'h00F1, 8'h03, 1'b1);
    rd_io(16'h00FD, 8'h00, "t0_reenable_clears");

    // Read on the 3->4 edge, 1->1 rewrite, then reset in mid-count
    do_reset();
    cycle(16'h00FC, 8'h01, 1'b1);
    cycle(16'h00F1, 8'h04, 1'b1);
    idle(61);
    rd_io(16'h00FF, 8'h03, "t2_read_on_3to4");
    rd_io(16'h00FF, 8'h01, "t2_inc_not_lost");
    idle(16);
    cycle(16'h00F1, 8'h04, 1'b1);
    rd_io(16'h00FF, 8'h01, "t2_rewrite_keeps");
    do_reset();
    rd_io(16'h00FF, 8'h00, "post_reset_t2");
    rd_io(16'h00FD, 8'h00, "post_reset_t0");

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      case (r)
        0:       cycle(16'h00F1, 8'($urandom_range(0, 255)), 1'b1);
        1, 2:    cycle(16'(16'h00FA + $urandom_range(0, 2)), 8'($urandom_range(0, 4)), 1'b1);
        3, 4, 5: cycle(16'(16'h00FD + $urandom_range(0, 2)), 8'h00, 1'b0);
        6:       cycle(16'(16'h00F0 + $urandom_range(0, 15)), 8'h00, 1'b0);
        7:       cycle(16'(16'h00F0 + $urandom_range(2, 9)), 8'($urandom_range(0, 255)), 1'b1);
        8, 9:    cycle(16'(16'h00E0 + $urandom_range(0, 47)), 8'($urandom_range(0, 255)), 1'b1);
        10, 11:  cycle(16'(16'h00E0 + $urandom_range(0, 47)), 8'h00, 1'b0);
        default: idle(1);
      endcase
      if (n == 0) cycle(16'h00F1, 8'h07, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spc_timer_io.md
SPC_TIMER_IO -- requirements
Module: spc_timer_io

Interface
REQ-001 Parameter T01_DIV, 128, clock cycles per timer 0/1 stage-1 tick (8 kHz at 1.024 MHz); power of two.
REQ-002 Parameter T2_DIV, 16, clock cycles per timer 2 stage-1 tick (64 kHz); power of two, divides T01_DIV.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 in_address  input  16  CPU bus address.
REQ-006 in_write  input  8  CPU write data.
REQ-007 in_write_enable  input  1  CPU write strobe; low means read cycle.
REQ-008 out_read  output  8  read data to CPU.
REQ-009 in_ram_read  input  8  synchronous BRAM read data, one-cycle latency.
REQ-010 out_ram_write_enable  output  1  gated write strobe to BRAM.

Function
REQ-011 The block SHALL decode in_address 0x00F0-0x00FF as the I/O window; all other addresses pass to RAM.
REQ-012 out_ram_write_enable SHALL equal in_write_enable AND NOT io_window, combinationally; I/O writes never reach RAM.
REQ-013 A registered io_sel flag SHALL capture io_window on every edge; out_read = io_sel ? io_data_reg : in_ram_read, giving one-cycle read latency matching BRAM.
REQ-014 io_data_reg SHALL capture, on read cycles: 0xFD/0xFE/0xFF -> {4'b0, T0OUT/T1OUT/T2OUT}; any other window address -> 0x00.
REQ-015 CONTROL (0xF1) write SHALL update enable bits [2:0] (timer 0..2); other bits ignored; CONTROL reads return 0x00.
REQ-016 Writes to 0xFA/0xFB/0xFC SHALL set the 8-bit T0DIV/T1DIV/T2DIV; divisor 0 means 256; registers are write-only.
REQ-017 Writes to other window addresses SHALL be discarded.
REQ-018 A free-running prescaler SHALL count 0..T01_DIV-1 and wrap; tick01 asserts when count = T01_DIV-1; tick2 when count mod T2_DIV = T2_DIV-1.
REQ-019 Per timer: 8-bit stage counter increments on its tick while enabled; when the incremented value equals TnDIV (8-bit compare, 0 matches wrap at 256), stage counter SHALL become 0 and 4-bit TnOUT SHALL increment mod 16.
REQ-020 A disabled timer SHALL hold stage counter and TnOUT.
REQ-021 An enable bit 0->1 transition SHALL clear that timer's stage counter and TnOUT on the same edge; a 1->1 rewrite clears nothing.
REQ-022 A read cycle of 0xFD-0xFF SHALL clear that TnOUT on the same edge; io_data_reg gets the pre-clear value.
REQ-023 A read-clear coinciding with a TnOUT increment SHALL leave TnOUT = 1 (increment not lost).
REQ-024 A held read address clears the counter on every cycle it is presented.
REQ-025 A TnDIV write takes effect on the next tick; a stage counter above the new divisor wraps through 255 to 0 before matching.

Reset
REQ-026 On reset assertion, immediately and asynchronously: CONTROL=0, TnDIV=0, stage counters=0, TnOUT=0, prescaler=0, io_sel=0, io_data_reg=0x00.
REQ-027 During reset out_read SHALL equal in_ram_read; out_ram_write_enable stays combinational per REQ-012.
REQ-028 Reset mid-count SHALL discard all timer progress; the first tick after release comes T2_DIV (tick2) or T01_DIV (tick01) cycles later.

Verification
REQ-029 Write 0x0012 = 0x5A, read 0x0012 -> out_ram_write_enable=1 on write; out_read=0x5A one cycle after the read address.
REQ-030 Write 0x00FD = 0x77 -> out_ram_write_enable=0; a later RAM read of 0x00FD is not produced; a CPU read of 0xFD returns 0x00.
REQ-031 After reset: FC=0x01, F1=0x04, wait 160 cycles, read 0xFF -> 0x0A (write-time phase within one count); an immediate second read returns 0x00.
REQ-032 T2DIV=1, T2 enabled, no reads for 256 cycles from enable -> T2OUT wraps to 0x00; at 240 cycles it reads 0x0F.
REQ-033 T0DIV=0 (256), T0 enabled -> T0OUT=1 after 256x128 cycles; disabling then re-enabling F1 bit 0 -> T0OUT and stage counter 0.
REQ-034 Read 0xFF on the cycle T2OUT goes 3->4 -> out_read=0x03, then T2OUT=1; assert reset mid-count -> all outputs 0 immediately.
